// File: rtl/mips_muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The pipeline side drives the instruction; the unit answers with results and handshake.
interface mips_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             valid;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic [WIDTH-1:0] rd_data;
   logic             stall;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output valid, funct, rs_data, rt_data,
      input  rd_data, stall, busy, done, div_by_zero, hi_out, lo_out
   );

   modport slave (
      input  valid, funct, rs_data, rt_data,
      output rd_data, stall, busy, done, div_by_zero, hi_out, lo_out
   );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Sequential MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Optional macro MULDIV_EARLY_TERM_EN ends multiply iterations once the multiplier runs out.
module mips_muldiv_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] HILO_RST = '0
) (
   input logic               clock,
   input logic               reset,
   mips_muldiv_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;      // mult: product; div: {remainder, quotient}
   logic [2*WIDTH-1:0] opa;      // mult: shifting multiplicand; div: divisor
   logic [WIDTH-1:0]   opb;      // mult: shifting multiplier; div: |dividend|
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               div_op;
   logic               neg_q;
   logic               neg_r;
   logic               dbz;
   logic               done_r;
   logic               dbz_r;

   // ---------------- decode ----------------
   logic             is_md;
   logic             is_mfmt;
   logic             op_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             busy;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      is_md     = (bus.funct[5:2] == 4'b0110);
      is_mfmt   = (bus.funct[5:2] == 4'b0100);
      op_signed = ~bus.funct[0];
      a_neg     = op_signed & bus.rs_data[WIDTH-1];
      b_neg     = op_signed & bus.rt_data[WIDTH-1];
      a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
      b_mag     = b_neg ? -bus.rt_data : bus.rt_data;
   end

   assign busy = (state != IDLE);

   // ---------------- iteration datapath ----------------
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic               q_bit;
   logic [2*WIDTH-1:0] div_acc;
   logic               calc_last;

   always_comb begin
      mul_acc = opb[0] ? acc + opa : acc;
      shifted = acc[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, opa[WIDTH-1:0]};
      q_bit   = ~diff[WIDTH];
      div_acc = {(q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
`ifdef MULDIV_EARLY_TERM_EN
      // Stop once no set multiplier bits remain above the one consumed this edge.
      calc_last = (cnt == '0) || (!div_op && (opb[WIDTH-1:1] == '0));
`else
      calc_last = (cnt == '0);
`endif
   end

   // ---------------- sign correction ----------------
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      prod = neg_q ? -acc : acc;
      if (dbz) begin
         // Divide by zero hands back the dividend untouched and an all-ones quotient.
         fix_lo = '1;
         fix_hi = neg_r ? -opb : opb;
      end else if (div_op) begin
         fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end else begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end
   end

   // ---------------- FSM and architectural state ----------------
   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opa    <= '0;
         opb    <= '0;
         hi     <= HILO_RST;
         lo     <= HILO_RST;
         div_op <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dbz    <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.valid && is_md) begin
                  state  <= CALC;
                  cnt    <= CW'(WIDTH - 1);
                  div_op <= bus.funct[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  dbz    <= bus.funct[1] && (bus.rt_data == '0);
                  if (bus.funct[1]) begin
                     acc <= {{WIDTH{1'b0}}, a_mag};
                     opa <= {{WIDTH{1'b0}}, b_mag};
                     opb <= a_mag;
                  end else begin
                     acc <= '0;
                     opa <= {{WIDTH{1'b0}}, a_mag};
                     opb <= b_mag;
                  end
               end else if (bus.valid && is_mfmt && bus.funct[0]) begin
                  if (bus.funct[1]) lo <= bus.rs_data;
                  else              hi <= bus.rs_data;
               end
            end
            CALC: begin
               cnt <= cnt - 1'b1;
               if (div_op) begin
                  acc <= div_acc;
               end else begin
                  acc <= mul_acc;
                  opa <= opa << 1;
                  opb <= opb >> 1;
               end
               if (calc_last) state <= FIXUP;
            end
            FIXUP: begin
               hi     <= fix_hi;
               lo     <= fix_lo;
               done_r <= 1'b1;
               dbz_r  <= dbz;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------- outputs ----------------
   logic [WIDTH-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      if (!busy && is_mfmt && !bus.funct[0]) rd_mux = bus.funct[1] ? lo : hi;
   end

   assign bus.rd_data     = rd_mux;
   assign bus.stall       = bus.valid & busy & (is_md | is_mfmt);
   assign bus.busy        = busy;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi_out      = hi;
   assign bus.lo_out      = lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus queues expected HI/LO/flag/cycle,
// a monitor compares them whenever done pulses.
module tb_mips_muldiv_unit;
   localparam int         W    = 32;
   localparam logic [W-1:0] HRST = 32'hC0DE_0001;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_ADD   = 6'b100000;

`ifdef MULDIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic clock = 1'b0;
   logic reset;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   mips_muldiv_unit_if #(.WIDTH(W)) bus ();

   mips_muldiv_unit #(.WIDTH(W), .HILO_RST(HRST)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Cycles from the issue cycle to the done cycle: CALC count plus FIXUP plus the done cycle.
   function automatic int exp_lat(input logic [5:0] f, input logic [W-1:0] b);
      int           n;
      logic [W-1:0] m;
      n = W;
      if (EARLY && (f == F_MULT || f == F_MULTU)) begin
         m = (f == F_MULT && b[W-1]) ? -b : b;
         n = 1;
         for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
      end
      return n + 2;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && bus.done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, "_hi"},  64'(bus.hi_out),      64'(mon_e.hi));
               check({mon_e.name, "_lo"},  64'(bus.lo_out),      64'(mon_e.lo));
               check({mon_e.name, "_dbz"}, 64'(bus.div_by_zero), 64'(mon_e.dbz));
               check({mon_e.name, "_cyc"}, 64'(cyc),             64'(mon_e.cyc));
            end
         end
      end
   end

   task automatic issue(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed);
      exp_t e;
      @(posedge clock); #1;
      bus.valid = 1'b1; bus.funct = f; bus.rs_data = a; bus.rt_data = b;
      #1 check({name, "_issue_stall"}, 64'(bus.stall), 64'd0);
      e.name = name; e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + exp_lat(f, b);
      sb.push_back(e);
      @(posedge clock); #1;
      bus.valid = 1'b0; bus.funct = F_ADD;
   endtask

   task automatic mt(input logic [5:0] f, input logic [W-1:0] v);
      @(posedge clock); #1;
      bus.valid = 1'b1; bus.funct = f; bus.rs_data = v;
      @(posedge clock); #1;
      bus.valid = 1'b0; bus.funct = F_ADD;
   endtask

   task automatic mf(input string name, input logic [5:0] f, input logic [W-1:0] exp);
      @(posedge clock); #1;
      bus.valid = 1'b1; bus.funct = f;
      #1 check(name, 64'(bus.rd_data), 64'(exp));
      @(posedge clock); #1;
      bus.valid = 1'b0; bus.funct = F_ADD;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clock);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      bus.valid = 1'b0; bus.funct = F_ADD; bus.rs_data = '0; bus.rt_data = '0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", 64'(bus.busy),        64'd0);
      check("rst_done", 64'(bus.done),        64'd0);
      check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
      check("rst_hi",   64'(bus.hi_out),      64'(HRST));
      check("rst_lo",   64'(bus.lo_out),      64'(HRST));
      reset = 1'b0;

      mt(F_MTHI, 32'h0000_0055);
      mt(F_MTLO, 32'h0000_0066);
      check("mthi_hi", 64'(bus.hi_out), 64'h55);
      check("mtlo_lo", 64'(bus.lo_out), 64'h66);
      mf("mfhi_rd", F_MFHI, 32'h0000_0055);
      mf("mflo_rd", F_MFLO, 32'h0000_0066);

      issue("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      drain();
      issue("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      drain();
      issue("mult_min",  F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      drain();
      issue("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      drain();
      issue("div_negd",  F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      drain();
      issue("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      drain();
      issue("divu_big",  F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
      drain();
      issue("divu_zero", F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
      drain();
      issue("div_zero",  F_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Reset in the middle of a divide: result must never appear.
      mt(F_MTHI, 32'h0000_0099);
      issue("div_abort", F_DIV, 32'd100, 32'd3, 32'd1, 32'd33, 1'b0);
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      sb.delete();
      #1;
      check("abort_busy", 64'(bus.busy),        64'd0);
      check("abort_hi",   64'(bus.hi_out),      64'(HRST));
      check("abort_lo",   64'(bus.lo_out),      64'(HRST));
      check("abort_dbz",  64'(bus.div_by_zero), 64'd0);
      @(posedge clock); #1 reset = 1'b0;
      repeat (45) @(posedge clock);
      mt(F_MTHI, 32'h0000_1234);
      mf("post_reset_mfhi", F_MFHI, 32'h0000_1234);

      issue("multu_small", F_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0);
      drain();

      // Stalled instructions while busy, then MFLO picks up the new LO in the done cycle.
      issue("mult_stall", F_MULT, 32'd7, 32'h0010_0006, 32'd0, 32'h0070_002A, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      bus.valid = 1'b1; bus.funct = F_MULT; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
      #1 check("busy_mult_stall", 64'(bus.stall), 64'd1);
      @(posedge clock); #1;
      bus.funct = F_MTHI; bus.rs_data = 32'h0000_DEAD;
      #1 check("busy_mthi_stall", 64'(bus.stall), 64'd1);
      @(posedge clock); #1;
      check("busy_mthi_no_write", 64'(bus.hi_out), 64'd0);
      check("busy_lo_held",       64'(bus.lo_out), 64'd15);
      bus.funct = F_ADD;
      #1 check("busy_unknown_no_stall", 64'(bus.stall), 64'd0);
      @(posedge clock); #1;
      bus.funct = F_MFLO;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (!bus.stall) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         check("mflo_done_cycle", 64'(bus.done),    64'd1);
         check("mflo_new_lo",     64'(bus.rd_data), 64'h0070_002A);
      end else begin
         total++;
         bad++;
         $display("FAIL mflo_stall_timeout: stall still 1 after 60 cycles, expected release");
      end
      @(posedge clock); #1;
      bus.valid = 1'b0; bus.funct = F_ADD;

      drain();
      repeat (2) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
